// File: rtl/qpsk_frame_sync_if.sv
// Symbol-in / dibit-out bundle of the QPSK frame synchroniser.
// master drives the symbol stream, slave is the synchroniser.
interface qpsk_frame_sync_if;
    logic       in_valid;
    logic       in_i_neg;
    logic       in_q_neg;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       locked;
    logic [1:0] hyp_rot;
    logic       hyp_swap;
    logic       sof_miss;

    modport master (
        output in_valid, in_i_neg, in_q_neg,
        input  out_valid, out_data, out_sof, out_eof, locked, hyp_rot, hyp_swap, sof_miss
    );

    modport slave (
        input  in_valid, in_i_neg, in_q_neg,
        output out_valid, out_data, out_sof, out_eof, locked, hyp_rot, hyp_swap, sof_miss
    );
endinterface

// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser: hunts SOF under 8 phase/swap hypotheses, then flywheels
// on the locked hypothesis and emits derotated payload dibits.
module qpsk_frame_sync #(
    parameter int                   SOF_LEN      = 26,
    parameter logic [2*SOF_LEN-1:0] SOF_PATTERN  = 52'hC935A7E1D246B,
    parameter int                   FRAME_LEN    = 63,
    parameter int                   HUNT_THRESH  = 24,
    parameter int                   TRACK_THRESH = 20,
    parameter int                   MISS_MAX     = 3
) (
    input  logic               clk,
    input  logic               rst,
    qpsk_frame_sync_if.slave   bus
);
    localparam int AW = $clog2(SOF_LEN + 1);
    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SW = $clog2(SOF_LEN);
    localparam int MW = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {HUNT, FRAME, CHECK} state_t;

    // rot() multiplies a {i_neg,q_neg} symbol by j
    function automatic logic [1:0] rot1(input logic [1:0] s);
        return {~s[0], s[1]};
    endfunction

    // Expected received symbol for pattern symbol p under hypothesis h = {swap,k}
    function automatic logic [1:0] hyp_sym(input logic [1:0] p, input int h);
        logic [1:0] s;
        s = p;
        for (int r = 0; r < (h % 4); r++) s = rot1(s);
        if (h >= 4) s = {s[0], s[1]};
        return s;
    endfunction

    // Undo the swap first, then rotate by -k (i.e. rot applied (4-k)%4 times)
    function automatic logic [1:0] derotate(input logic [1:0] s, input logic [1:0] k, input logic swap);
        logic [1:0] d;
        logic [1:0] r;
        d = swap ? {s[0], s[1]} : s;
        case (k)
            2'd1:    r = {d[0], ~d[1]};
            2'd2:    r = ~d;
            2'd3:    r = {~d[0], d[1]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t              state_reg;
    logic [2*SOF_LEN-3:0] shift_reg;
    logic [SW-1:0]       fill_cnt_reg;
    logic [PW-1:0]       pay_cnt_reg;
    logic [SW-1:0]       sof_cnt_reg;
    logic [MW-1:0]       miss_cnt_reg;
    logic                out_valid_reg, out_sof_reg, out_eof_reg, sof_miss_reg, locked_reg;
    logic [1:0]          out_data_reg, hyp_rot_reg;
    logic                hyp_swap_reg;

    logic [1:0]           sym;
    logic [2*SOF_LEN-1:0] window;
    logic                 window_full;
    logic [AW-1:0]        agree [8];
    logic [AW-1:0]        best_val;
    logic [2:0]           best_idx;
    logic [AW-1:0]        locked_agree;

    assign sym         = {bus.in_i_neg, bus.in_q_neg};
    // Oldest symbol sits at window[1:0], aligned with pattern symbol 0
    assign window      = {sym, shift_reg};
    assign window_full = (fill_cnt_reg == SW'(SOF_LEN - 1));

    for (genvar gi = 0; gi < 8; gi++) begin : g_hyp
        logic [SOF_LEN-1:0] match;
        logic [AW-1:0]      count;
        for (genvar gn = 0; gn < SOF_LEN; gn++) begin : g_sym
            localparam logic [1:0] EXP = hyp_sym(SOF_PATTERN[2*gn +: 2], gi);
            assign match[gn] = (window[2*gn +: 2] == EXP);
        end
        always_comb begin
            count = '0;
            for (int n = 0; n < SOF_LEN; n++) count = count + AW'(match[n]);
        end
        assign agree[gi] = count;
    end

    // Strict '>' keeps the lowest index on ties
    always_comb begin
        best_val = agree[0];
        best_idx = 3'd0;
        for (int h = 1; h < 8; h++) begin
            if (agree[h] > best_val) begin
                best_val = agree[h];
                best_idx = 3'(h);
            end
        end
    end

    assign locked_agree = agree[{hyp_swap_reg, hyp_rot_reg}];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            shift_reg     <= '0;
            fill_cnt_reg  <= '0;
            pay_cnt_reg   <= '0;
            sof_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 2'b00;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            sof_miss_reg  <= 1'b0;
            locked_reg    <= 1'b0;
            hyp_rot_reg   <= 2'b00;
            hyp_swap_reg  <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            sof_miss_reg  <= 1'b0;
            if (bus.in_valid) begin
                shift_reg <= window[2*SOF_LEN-1:2];
                if (!window_full) fill_cnt_reg <= fill_cnt_reg + 1'b1;
                case (state_reg)
                    HUNT: begin
                        if (window_full && best_val >= AW'(HUNT_THRESH)) begin
                            hyp_rot_reg  <= best_idx[1:0];
                            hyp_swap_reg <= best_idx[2];
                            miss_cnt_reg <= '0;
                            pay_cnt_reg  <= '0;
                            state_reg    <= FRAME;
                            locked_reg   <= 1'b1;
                        end
                    end
                    FRAME: begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= derotate(sym, hyp_rot_reg, hyp_swap_reg);
                        out_sof_reg   <= (pay_cnt_reg == '0);
                        out_eof_reg   <= (pay_cnt_reg == PW'(FRAME_LEN - 1));
                        if (pay_cnt_reg == PW'(FRAME_LEN - 1)) begin
                            pay_cnt_reg <= '0;
                            sof_cnt_reg <= '0;
                            state_reg   <= CHECK;
                        end else begin
                            pay_cnt_reg <= pay_cnt_reg + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (sof_cnt_reg == SW'(SOF_LEN - 1)) begin
                            sof_cnt_reg <= '0;
                            if (locked_agree >= AW'(TRACK_THRESH)) begin
                                miss_cnt_reg <= '0;
                                state_reg    <= FRAME;
                            end else begin
                                sof_miss_reg <= 1'b1;
                                miss_cnt_reg <= miss_cnt_reg + 1'b1;
                                if (miss_cnt_reg == MW'(MISS_MAX - 1)) begin
                                    state_reg  <= HUNT;
                                    locked_reg <= 1'b0;
                                end else begin
                                    state_reg  <= FRAME;
                                end
                            end
                        end else begin
                            sof_cnt_reg <= sof_cnt_reg + 1'b1;
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sof   = out_sof_reg;
    assign bus.out_eof   = out_eof_reg;
    assign bus.locked    = locked_reg;
    assign bus.hyp_rot   = hyp_rot_reg;
    assign bus.hyp_swap  = hyp_swap_reg;
    assign bus.sof_miss  = sof_miss_reg;
endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Randomised bench for qpsk_frame_sync: channel-impaired streams are checked every cycle
// against a position-based model using complex-point arithmetic, plus scenario literals.
module tb_qpsk_frame_sync;
    localparam int          SOF_LEN      = 26;
    localparam logic [51:0] SOF_PATTERN  = 52'hC935A7E1D246B;
    localparam int          FRAME_LEN    = 63;
    localparam int          HUNT_THRESH  = 24;
    localparam int          TRACK_THRESH = 20;
    localparam int          MISS_MAX     = 3;
    localparam int          PERIOD       = FRAME_LEN + SOF_LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    qpsk_frame_sync_if bus();

    qpsk_frame_sync #(
        .SOF_LEN(SOF_LEN), .SOF_PATTERN(SOF_PATTERN), .FRAME_LEN(FRAME_LEN),
        .HUNT_THRESH(HUNT_THRESH), .TRACK_THRESH(TRACK_THRESH), .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Symbols as complex points: x = 1-2*i_neg, y = 1-2*q_neg
    function automatic logic [1:0] to_bits(input int x, input int y);
        return {x < 0, y < 0};
    endfunction

    function automatic logic [1:0] chan(input logic [1:0] s, input int k, input int sw);
        int x, y, t;
        x = s[1] ? -1 : 1;
        y = s[0] ? -1 : 1;
        for (int r = 0; r < k; r++) begin t = x; x = -y; y = t; end
        if (sw != 0) begin t = x; x = y; y = t; end
        return to_bits(x, y);
    endfunction

    function automatic logic [1:0] derot(input logic [1:0] s, input int k, input int sw);
        int x, y, t;
        x = s[1] ? -1 : 1;
        y = s[0] ? -1 : 1;
        if (sw != 0) begin t = x; x = y; y = t; end
        for (int r = 0; r < k; r++) begin t = x; x = y; y = -t; end
        return to_bits(x, y);
    endfunction

    function automatic logic [1:0] pat(input int n);
        logic [51:0] p;
        p = SOF_PATTERN;
        return p[2*n +: 2];
    endfunction

    // ---------------- model ----------------
    logic [1:0] hist[$];
    bit         m_lock;
    int         m_rot, m_swap, m_pos, m_miss;
    bit         e_valid, e_sof, e_eof, e_miss;
    logic [1:0] e_data;
    logic       s_rst, s_valid;
    logic [1:0] s_sym;

    function automatic int agree_h(input int k, input int sw);
        int a;
        a = 0;
        for (int n = 0; n < SOF_LEN; n++) if (hist[n] == chan(pat(n), k, sw)) a++;
        return a;
    endfunction

    always @(posedge clk) begin
        s_rst   <= rst;
        s_valid <= bus.in_valid;
        s_sym   <= {bus.in_i_neg, bus.in_q_neg};
    end

    // Model step for the edge just passed, then compare against the DUT
    always @(negedge clk) begin
        if (cmp_en) begin
            e_valid = 0; e_sof = 0; e_eof = 0; e_miss = 0;
            if (s_rst) begin
                hist.delete();
                m_lock = 0; m_rot = 0; m_swap = 0; m_pos = 0; m_miss = 0; e_data = 2'b00;
            end else if (s_valid) begin
                hist.push_back(s_sym);
                if (hist.size() > SOF_LEN) void'(hist.pop_front());
                if (!m_lock) begin
                    if (hist.size() == SOF_LEN) begin
                        int best, bh, a;
                        best = -1; bh = 0;
                        for (int h = 0; h < 8; h++) begin
                            a = agree_h(h % 4, h / 4);
                            if (a > best) begin best = a; bh = h; end
                        end
                        if (best >= HUNT_THRESH) begin
                            m_lock = 1; m_rot = bh % 4; m_swap = bh / 4; m_pos = 0; m_miss = 0;
                        end
                    end
                end else begin
                    if (m_pos < FRAME_LEN) begin
                        e_valid = 1;
                        e_data  = derot(s_sym, m_rot, m_swap);
                        e_sof   = (m_pos == 0);
                        e_eof   = (m_pos == FRAME_LEN - 1);
                    end else if (m_pos == PERIOD - 1) begin
                        if (agree_h(m_rot, m_swap) >= TRACK_THRESH) m_miss = 0;
                        else begin
                            e_miss = 1;
                            m_miss++;
                            if (m_miss == MISS_MAX) m_lock = 0;
                        end
                    end
                    m_pos = (m_pos + 1) % PERIOD;
                end
            end
            check("out_valid", bus.out_valid, e_valid);
            check("locked", bus.locked, m_lock);
            check("hyp_rot", bus.hyp_rot, m_rot);
            check("hyp_swap", bus.hyp_swap, m_swap);
            check("sof_miss", bus.sof_miss, e_miss);
            if (e_valid) begin
                check("out_data", bus.out_data, e_data);
                check("out_sof", bus.out_sof, e_sof);
                check("out_eof", bus.out_eof, e_eof);
            end
        end
    end

    // ---------------- capture ----------------
    logic [1:0] rxq[$];
    int n_valid, n_sof, n_eof, n_miss;

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            if (bus.out_valid) begin
                rxq.push_back(bus.out_data);
                n_valid++;
                if (bus.out_sof) n_sof++;
                if (bus.out_eof) n_eof++;
            end
            if (bus.sof_miss) n_miss++;
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] stream[$], txq[$], stream1[$], tx1[$];

    task automatic new_stream();
        stream.delete();
        txq.delete();
    endtask

    task automatic add_random(input int n);
        repeat (n) stream.push_back(2'($urandom_range(0, 3)));
    endtask

    // Errors invert whole symbols at positions 1,4,7,... so each costs one agreement
    task automatic add_sof(input int k, input int sw, input int nerr);
        logic [1:0] s;
        for (int n = 0; n < SOF_LEN; n++) begin
            s = chan(pat(n), k, sw);
            if (n % 3 == 1 && n / 3 < nerr) s = s ^ 2'b11;
            stream.push_back(s);
        end
    endtask

    task automatic add_payload(input int k, input int sw, input bit rec);
        logic [1:0] tx;
        repeat (FRAME_LEN) begin
            tx = 2'($urandom_range(0, 3));
            if (rec) txq.push_back(tx);
            stream.push_back(chan(tx, k, sw));
        end
    endtask

    task automatic play(input int first, input int last, input bit gaps);
        for (int i = first; i < last; i++) begin
            if (gaps && $urandom_range(0, 7) != 0) begin
                repeat ($urandom_range(1, 5)) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            {bus.in_i_neg, bus.in_q_neg} = stream[i];
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        n_valid = 0; n_sof = 0; n_eof = 0; n_miss = 0;
    endtask

    task automatic check_rx(input string name);
        int n;
        check({name, "_count"}, rxq.size(), txq.size());
        n = (rxq.size() < txq.size()) ? rxq.size() : txq.size();
        for (int i = 0; i < n; i++) check({name, "_data"}, rxq[i], txq[i]);
    endtask

    task automatic two_frames(input int k, input int sw);
        new_stream();
        add_random(30);
        add_sof(k, sw, 0); add_payload(k, sw, 1);
        add_sof(k, sw, 0); add_payload(k, sw, 1);
    endtask

    initial begin
        int mark;
        bus.in_valid = 1'b0; bus.in_i_neg = 1'b0; bus.in_q_neg = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        do_reset();

        // Model pins: j*(+1+j) = (-1+j); swap of (+1-j) = (-1+j)
        check("pin_rot", chan(2'b00, 1, 0), 2'b10);
        check("pin_swap", chan(2'b01, 0, 1), 2'b10);
        check("pin_derot", derot(2'b10, 1, 0), 2'b00);

        // 1: clean stream, k=0
        two_frames(0, 0);
        stream1 = stream; tx1 = txq;
        play(0, stream.size(), 0); idle(4);
        check("t1_locked", bus.locked, 1);
        check("t1_valid", n_valid, 126);
        check("t1_sof", n_sof, 2);
        check("t1_eof", n_eof, 2);
        check_rx("t1_rx");

        // 2: ambiguity sweep
        for (int k = 0; k < 4; k++) begin
            for (int sw = 0; sw < 2; sw++) begin
                do_reset();
                two_frames(k, sw);
                play(0, stream.size(), 0); idle(4);
                check("t2_rot", bus.hyp_rot, k);
                check("t2_swap", bus.hyp_swap, sw);
                check_rx("t2_rx");
            end
        end

        // 3a: 2 SOF errors lock; 7 errors in CHECK give one miss, output continues
        do_reset(); new_stream();
        add_random(30);
        add_sof(2, 1, 2); add_payload(2, 1, 1);
        add_sof(2, 1, 7); add_payload(2, 1, 1);
        play(0, stream.size(), 0); idle(4);
        check("t3_locked", bus.locked, 1);
        check("t3_miss", n_miss, 1);
        check_rx("t3_rx");

        // 3b: 3 SOF errors in HUNT never lock
        do_reset(); new_stream();
        add_random(30);
        add_sof(0, 0, 3); add_payload(0, 0, 0);
        play(0, stream.size(), 0); idle(4);
        check("t3b_locked", bus.locked, 0);
        check("t3b_valid", n_valid, 0);

        // 4: three corrupted SOFs drop lock, next clean SOF reacquires
        do_reset(); new_stream();
        add_random(30);
        add_sof(1, 0, 0); add_payload(1, 0, 1);
        add_sof(1, 0, 8); add_payload(1, 0, 1);
        add_sof(1, 0, 8); add_payload(1, 0, 1);
        add_sof(1, 0, 8);
        mark = stream.size();
        add_payload(1, 0, 0);
        add_sof(1, 0, 0); add_payload(1, 0, 1);
        play(0, mark, 0); idle(2);
        check("t4_drop", bus.locked, 0);
        check("t4_miss", n_miss, 3);
        play(mark, stream.size(), 0); idle(4);
        check("t4_relock", bus.locked, 1);
        check_rx("t4_rx");

        // 5: gapped stream reproduces test 1
        do_reset();
        stream = stream1; txq = tx1;
        play(0, stream.size(), 1); idle(4);
        check("t5_valid", n_valid, 126);
        check_rx("t5_rx");

        // 6: reset mid-payload with in_valid high
        do_reset();
        stream = stream1; txq = tx1;
        play(0, 30 + SOF_LEN + 20, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("t6_locked", bus.locked, 0);
        check("t6_valid", bus.out_valid, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        rxq.delete();
        play(0, stream.size(), 0); idle(4);
        check("t6_relock", bus.locked, 1);
        check_rx("t6_rx");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
